mux2_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 2:1 multiplexed output channel between two streaming requesters, A and B.
- Drives the 2:1 datapath select internally and routes valid/ready handshakes.
- Grant is held for a whole packet, delimited by a last flag.
- Sits in front of any single-consumer sink that two producers must share.

---
 rtl/mux2_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter driving one 2:1 muxed stream channel, grant held per packet.
// Latency: 1 cycle from valid seen in IDLE to first beat eligible; beats pass combinationally while granted.
// Backpressure: granted requester's ready follows c_ready; the other requester sees ready=0 and must hold.
//
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   a_* / b_*         : requester streams (valid, data, last, ready)
//   c_*               : shared output stream (valid, data, last, ready)
//   sel               : registered mux select, 0=A, 1=B
//   busy              : high while a grant is held
//   err_long          : sticky, a packet reached MAX_BEATS non-last beats
//   pkt_cnt_a/b       : completed-packet counters, wrap modulo 2^CNT_W
module mux2_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             c_valid,
    output logic [WIDTH-1:0] c_data,
    output logic             c_last,
    input  logic             c_ready,
    output logic             sel,
    output logic             busy,
    output logic             err_long,
    output logic [CNT_W-1:0] pkt_cnt_a,
    output logic [CNT_W-1:0] pkt_cnt_b
);

    localparam int            BC_W   = $clog2(MAX_BEATS + 1);
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(MAX_BEATS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_A = 2'd1,
        S_GRANT_B = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_sel;
    logic              r_ptr;       // 0: A wins a tie, 1: B wins a tie
    logic              r_busy;
    logic              r_err_long;
    logic [BC_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]  r_pkt_cnt_a;
    logic [CNT_W-1:0]  r_pkt_cnt_b;

    logic              w_gnt_a;
    logic              w_gnt_b;
    logic              w_xfer;

    // Datapath: sel always tracks the current grant, so the mux follows sel
    // in every state; only valid/ready are qualified by the grant.
    always_comb begin
        w_gnt_a = (r_state == S_GRANT_A);
        w_gnt_b = (r_state == S_GRANT_B);
        c_data  = r_sel ? b_data : a_data;
        c_last  = r_sel ? b_last : a_last;
        c_valid = (w_gnt_a & a_valid) | (w_gnt_b & b_valid);
        a_ready = w_gnt_a & c_ready;
        b_ready = w_gnt_b & c_ready;
        w_xfer  = c_valid & c_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sel       <= 1'b0;
            r_ptr       <= 1'b0;
            r_busy      <= 1'b0;
            r_err_long  <= 1'b0;
            r_beat_cnt  <= '0;
            r_pkt_cnt_a <= '0;
            r_pkt_cnt_b <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A wins when alone or when the pointer favours it.
                    if (a_valid && (!b_valid || !r_ptr)) begin
                        r_state <= S_GRANT_A;
                        r_sel   <= 1'b0;
                        r_busy  <= 1'b1;
                    end else if (b_valid) begin
                        r_state <= S_GRANT_B;
                        r_sel   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_GRANT_A, S_GRANT_B: begin
                    if (w_xfer) begin
                        if (c_last) begin
                            // Release after the last beat; the forced IDLE
                            // bubble gives the pointer time to take effect.
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                            r_beat_cnt <= '0;
                            if (w_gnt_a) begin
                                r_ptr       <= 1'b1;
                                r_pkt_cnt_a <= r_pkt_cnt_a + 1'b1;
                            end else begin
                                r_ptr       <= 1'b0;
                                r_pkt_cnt_b <= r_pkt_cnt_b + 1'b1;
                            end
                        end else if (r_beat_cnt != BC_MAX) begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                            if (r_beat_cnt == BC_MAX - 1'b1) begin
                                r_err_long <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sel       = r_sel;
    assign busy      = r_busy;
    assign err_long  = r_err_long;
    assign pkt_cnt_a = r_pkt_cnt_a;
    assign pkt_cnt_b = r_pkt_cnt_b;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: reset, packet transfer, fairness, stall, long packet, mid-packet reset, counter wrap.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 time unit after that.
// Expected values are hand-computed from the intended arbitration and counting behaviour.
module tb_mux2_rr_arbiter;

    localparam int WIDTH     = 8;
    localparam int MAX_BEATS = 16;
    localparam int CNT_W     = 8;

    logic             clk;
    logic             rst;
    logic             a_valid, a_last, a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid, b_last, b_ready;
    logic [WIDTH-1:0] b_data;
    logic             c_valid, c_last, c_ready;
    logic [WIDTH-1:0] c_data;
    logic             sel, busy, err_long;
    logic [CNT_W-1:0] pkt_cnt_a, pkt_cnt_b;

    int n_checks;
    int n_errs;
    logic exp_sel;

    mux2_rr_arbiter #(
        .WIDTH     (WIDTH),
        .MAX_BEATS (MAX_BEATS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_last    (a_last),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_last    (b_last),
        .b_ready   (b_ready),
        .c_valid   (c_valid),
        .c_data    (c_data),
        .c_last    (c_last),
        .c_ready   (c_ready),
        .sel       (sel),
        .busy      (busy),
        .err_long  (err_long),
        .pkt_cnt_a (pkt_cnt_a),
        .pkt_cnt_b (pkt_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance past one rising edge; inputs are then driven at +1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errs   = 0;

        // ---------------- Reset with both requesters valid ----------------
        rst = 1'b1; c_ready = 1'b1;
        a_valid = 1'b1; a_data = 8'h11; a_last = 1'b0;
        b_valid = 1'b1; b_data = 8'hB0; b_last = 1'b0;
        step();
        step();
        settle();
        check("rst_busy",  busy, 0);
        check("rst_sel",   sel, 0);
        check("rst_err",   err_long, 0);
        check("rst_cnt_a", pkt_cnt_a, 0);
        check("rst_cnt_b", pkt_cnt_b, 0);
        check("rst_cvld",  c_valid, 0);
        check("rst_ardy",  a_ready, 0);
        check("rst_brdy",  b_ready, 0);
        rst = 1'b0;

        // ---------------- First grant A, 3-beat A packet ----------------
        step();
        b_valid = 1'b0;
        settle();
        check("a3_busy", busy, 1);
        check("a3_sel",  sel, 0);
        check("a3_cvld", c_valid, 1);
        check("a3_d0",   c_data, 8'h11);
        check("a3_ardy", a_ready, 1);
        check("a3_brdy", b_ready, 0);
        step();
        a_data = 8'h22;
        settle();
        check("a3_d1",   c_data, 8'h22);
        check("a3_l1",   c_last, 0);
        check("a3_brdy1", b_ready, 0);
        step();
        a_data = 8'h33; a_last = 1'b1;
        settle();
        check("a3_d2",   c_data, 8'h33);
        check("a3_l2",   c_last, 1);
        check("a3_brdy2", b_ready, 0);
        step();
        a_valid = 1'b0;
        settle();
        check("a3_idle", busy, 0);
        check("a3_cnt",  pkt_cnt_a, 1);
        check("a3_cvld_idle", c_valid, 0);

        // ---------------- Fairness, 1-beat packets, both valid ----------------
        // Pointer now favours B (A just finished).
        a_valid = 1'b1; a_last = 1'b1; a_data = 8'hA5;
        b_valid = 1'b1; b_last = 1'b1; b_data = 8'hB5;
        exp_sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            settle();
            check("rr_busy", busy, 1);
            check("rr_sel",  sel, exp_sel);
            check("rr_data", c_data, exp_sel ? 8'hB5 : 8'hA5);
            exp_sel = ~exp_sel;
            step();
            settle();
            check("rr_bubble", busy, 0);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        check("rr_cnt_a", pkt_cnt_a, 5);
        check("rr_cnt_b", pkt_cnt_b, 4);

        // ---------------- Backpressure on a 2-beat B packet, A waiting ----------------
        b_valid = 1'b1; b_data = 8'h51; b_last = 1'b0;
        a_valid = 1'b1; a_data = 8'h99; a_last = 1'b1;
        step();
        settle();
        check("bp_sel",  sel, 1);
        check("bp_d0",   c_data, 8'h51);
        check("bp_ardy", a_ready, 0);
        c_ready = 1'b0;
        settle();
        for (int k = 0; k < 3; k++) begin
            check("bp_stall_brdy", b_ready, 0);
            check("bp_stall_data", c_data, 8'h51);
            check("bp_stall_sel",  sel, 1);
            step();
        end
        c_ready = 1'b1;
        settle();
        check("bp_d0_again", c_data, 8'h51);
        step();
        b_data = 8'h52; b_last = 1'b1;
        settle();
        check("bp_d1",   c_data, 8'h52);
        check("bp_l1",   c_last, 1);
        check("bp_ardy1", a_ready, 0);
        step();
        b_valid = 1'b0;
        settle();
        check("bp_idle",  busy, 0);
        check("bp_cnt_b", pkt_cnt_b, 5);
        step();
        settle();
        check("bp_a_sel",  sel, 0);
        check("bp_a_data", c_data, 8'h99);
        step();
        a_valid = 1'b0;
        settle();
        check("bp_cnt_a", pkt_cnt_a, 6);

        // ---------------- Long A packet ----------------
        a_valid = 1'b1; a_last = 1'b0; a_data = 8'h77;
        step();                                   // grant A
        for (int k = 1; k <= MAX_BEATS; k++) begin
            step();                               // k-th non-last transfer
            settle();
            if (k == MAX_BEATS - 1) check("long_err_early", err_long, 0);
            if (k == MAX_BEATS)     check("long_err_set", err_long, 1);
        end
        step();
        step();                                   // beats past saturation
        a_last = 1'b1;
        settle();
        check("long_still_busy", busy, 1);
        step();
        a_valid = 1'b0;
        settle();
        check("long_idle",  busy, 0);
        check("long_cnt_a", pkt_cnt_a, 7);
        check("long_err_after", err_long, 1);
        b_valid = 1'b1; b_last = 1'b1; b_data = 8'h3C;
        step();
        step();
        b_valid = 1'b0;
        settle();
        check("long_cnt_b", pkt_cnt_b, 6);
        check("long_err_sticky", err_long, 1);

        // ---------------- Reset during 2nd beat of a B packet ----------------
        b_valid = 1'b1; b_last = 1'b0; b_data = 8'h61;
        step();                                   // grant B
        step();                                   // beat 1 transferred
        b_data = 8'h62;
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        check("mrst_busy",  busy, 0);
        check("mrst_cnt_b", pkt_cnt_b, 0);
        check("mrst_err",   err_long, 0);
        check("mrst_sel",   sel, 0);
        a_valid = 1'b1; a_last = 1'b1; a_data = 8'h0A;
        step();
        b_valid = 1'b0;
        settle();
        check("mrst_ptr_sel", sel, 0);
        check("mrst_ptr_data", c_data, 8'h0A);
        step();
        settle();
        check("mrst_cnt_a", pkt_cnt_a, 1);

        // ---------------- pkt_cnt_a wrap ----------------
        for (int i = 0; i < 255; i++) begin
            step();
            step();
            settle();
            if (i == 253) check("wrap_max", pkt_cnt_a, 255);
        end
        a_valid = 1'b0;
        check("wrap_zero", pkt_cnt_a, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
